tdc_multi_report: RTL and testbench

//  Multi-channel successor to the single-channel measurement buffer/rate limiter in the TDC top level.

---
 rtl/tdc_pkg.sv | 28 ++
 rtl/tdc_chan_fifo.sv | 73 +++++++
 rtl/tdc_multi_report.sv | 206 ++++++++++++++++++++
 tb/tb_tdc_multi_report.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the multi-channel TDC report path.
//  - Record tag layout: tag[7] = lost flag, tag[6:0] = channel id.
//  - Report FSM state encoding.
//  - Default measurement width.
package tdc_pkg;

  localparam int TAG_W      = 8;
  localparam int LOST_BIT   = 7;
  localparam int CHID_W     = 7;
  localparam int DEF_MEAS_W = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } fsm_t;

  // Build the 8-bit record tag from the lost flag and the channel id.
  function automatic logic [TAG_W-1:0] make_tag(input logic lost,
                                                input logic [CHID_W-1:0] ch_id);
    logic [TAG_W-1:0] tag;
    tag           = {1'b0, ch_id};
    tag[LOST_BIT] = lost;
    return tag;
  endfunction

endpackage

// File: rtl/tdc_chan_fifo.sv
// Per-channel measurement FIFO with overflow policy.
//  clk, rst : clock, asynchronous active-high reset (pointers only)
//  push     : write din this cycle
//  pop      : remove head this cycle (ignored when empty)
//  din      : measurement to store
//  dout     : current head (valid when !empty)
//  empty    : no entries stored
//  full     : DEPTH entries stored
//  ovf      : push into a full FIFO without a same-cycle pop (a sample is lost)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tdc_chan_fifo
  import tdc_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MEAS_W      = DEF_MEAS_W,
  parameter bit DROP_OLDEST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [MEAS_W-1:0] din,
  output logic [MEAS_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [MEAS_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_pop;
  logic              do_write;
  logic              adv_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ovf   = push && full && !pop;

  assign do_pop   = pop && !empty;
  // On a full FIFO the write slot is the head slot, so evicting the oldest
  // entry is simply "write, then advance both pointers".
  assign do_write = push && (!full || do_pop || DROP_OLDEST);
  assign adv_rd   = do_pop || (ovf && DROP_OLDEST);
  assign dout     = mem[rd_ptr[AW-1:0]];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Read and write pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (adv_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/tdc_multi_report.sv
// Multi-channel TDC measurement buffer, round-robin arbiter and rate limiter.
//  clk, rst   : system clock, asynchronous active-high reset
//  ch_meas    : channel i measurement at [i*MEAS_W +: MEAS_W]
//  ch_valid   : per-channel 1-cycle measurement strobe
//  tx_busy    : UART sender busy
//  tx_start   : 1-cycle start pulse to UART sender
//  tx_data    : {tag, meas}; tag = {lost, ch_id[6:0]}
//  ch_pending : per-channel FIFO non-empty
//  drop_count : total samples lost to overflow, saturating
module tdc_multi_report
  import tdc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int MEAS_W      = DEF_MEAS_W,
  parameter int DEPTH       = 4,
  parameter int CLKS_PER_TX = 5_000_000,
  parameter int RATE_W      = 24,
  parameter bit DROP_OLDEST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*MEAS_W-1:0] ch_meas,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [MEAS_W+TAG_W-1:0]  tx_data,
  output logic [NUM_CH-1:0]        ch_pending,
  output logic [15:0]              drop_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(CLKS_PER_TX);
  localparam logic [RATE_W-1:0] RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  RR_INIT  = IDX_W'(NUM_CH - 1);

  logic [MEAS_W-1:0] fifo_dout [NUM_CH];
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] drop_evt;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] lost;
  logic [IDX_W-1:0]  rr;
  logic [IDX_W-1:0]  sel;
  logic              found;
  logic [CHID_W-1:0] ch_id;
  logic [RATE_W-1:0] rate_cnt;
  logic              can_tx;
  logic              issue;
  logic [16:0]       drop_add;
  logic [16:0]       drop_sum;
  fsm_t              state;
  fsm_t              state_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    tdc_chan_fifo #(
      .DEPTH      (DEPTH),
      .MEAS_W     (MEAS_W),
      .DROP_OLDEST(DROP_OLDEST)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (ch_valid[g]),
      .pop  (pop[g]),
      .din  (ch_meas[g*MEAS_W +: MEAS_W]),
      .dout (fifo_dout[g]),
      .empty(empty[g]),
      .full (full[g]),
      .ovf  (ovf[g])
    );
  end

  assign ch_pending = ~empty;
  assign can_tx     = (rate_cnt >= RATE_MAX);
  assign issue      = (state == ISSUE);
  // Overflow can only originate from a full FIFO; qualifying with full keeps
  // the loss accounting tied to actual occupancy.
  assign drop_evt   = ovf & full;

  // Round-robin pick: first pending channel after the last one served.
  always_comb begin : sel_scan
    int idx;
    idx   = 0;
    sel   = rr;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(rr) + k) % NUM_CH;
      if (!found && !empty[IDX_W'(idx)]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end else begin
        found = found;
      end
    end
  end

  // Zero-extended channel id and one-hot pop of the selected FIFO.
  always_comb begin
    ch_id             = '0;
    ch_id[IDX_W-1:0]  = sel;
    pop               = '0;
    if (issue && found) begin
      pop[sel] = 1'b1;
    end else begin
      pop = '0;
    end
  end

  // Number of overflows this cycle added to the saturating drop counter.
  always_comb begin
    drop_add = 17'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_add = drop_add + {16'd0, drop_evt[i]};
    end
    drop_sum = {1'b0, drop_count} + drop_add;
  end

  // Report FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if ((|ch_pending) && can_tx && !tx_busy) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: state_next = SEND;
      SEND:  state_next = WAIT;
      // Staying requires busy to be high; a sender that never raises busy by
      // the cycle after tx_start therefore releases the FSM two cycles later.
      WAIT: begin
        if (tx_busy) begin
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Rate counter: saturates at CLKS_PER_TX, restarts on every issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_cnt <= RATE_MAX;
    end else if (issue) begin
      rate_cnt <= '0;
    end else if (rate_cnt < RATE_MAX) begin
      rate_cnt <= rate_cnt + RATE_ONE;
    end
  end

  // Arbiter pointer follows the channel served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= RR_INIT;
    end else if (issue && found) begin
      rr <= sel;
    end
  end

  // Lost flags: cleared when reported, a same-cycle overflow sets them again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost <= '0;
    end else begin
      lost <= drop_evt | (lost & ~pop);
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= 16'd0;
    end else if (drop_sum[16]) begin
      drop_count <= 16'hFFFF;
    end else begin
      drop_count <= drop_sum[15:0];
    end
  end

  // Registered record and start pulse; tx_data holds until the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= issue;
      if (issue) begin
        tx_data <= {make_tag(lost[sel], ch_id), fifo_dout[sel]};
      end
    end
  end

endmodule

// File: tb/tb_tdc_multi_report.sv
// Self-checking bench for tdc_multi_report.
// Two instances share clock and reset:
//  dut_a : CLKS_PER_TX=0,   DROP_OLDEST=1
//  dut_b : CLKS_PER_TX=100, DROP_OLDEST=0
// A queue-based reference model per instance predicts records, pending
// masks and drop counts from the behavioural rules.
module tb_tdc_multi_report;

  localparam int NCH = 4;
  localparam int MW  = 40;
  localparam int DEP = 4;

  logic              clk;
  logic              rst;
  logic [NCH*MW-1:0] ch_meas    [2];
  logic [NCH-1:0]    ch_valid   [2];
  logic              tx_busy    [2];
  logic              tx_start   [2];
  logic [MW+7:0]     tx_data    [2];
  logic [NCH-1:0]    ch_pending [2];
  logic [15:0]       drop_count [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [MW-1:0] mq [2*NCH][$];
  bit            lost_m [2*NCH];
  int            rr_m [2];
  int            drops_m [2];

  tdc_multi_report #(
    .NUM_CH(NCH), .MEAS_W(MW), .DEPTH(DEP),
    .CLKS_PER_TX(0), .RATE_W(24), .DROP_OLDEST(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .ch_meas(ch_meas[0]), .ch_valid(ch_valid[0]),
    .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .ch_pending(ch_pending[0]), .drop_count(drop_count[0])
  );

  tdc_multi_report #(
    .NUM_CH(NCH), .MEAS_W(MW), .DEPTH(DEP),
    .CLKS_PER_TX(100), .RATE_W(24), .DROP_OLDEST(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .ch_meas(ch_meas[1]), .ch_valid(ch_valid[1]),
    .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .ch_pending(ch_pending[1]), .drop_count(drop_count[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 2*NCH; q++) begin
      mq[q].delete();
      lost_m[q] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      rr_m[d]    = NCH - 1;
      drops_m[d] = 0;
    end
  endtask

  function automatic int model_total(input int d);
    int t = 0;
    for (int c = 0; c < NCH; c++) t += mq[d*NCH+c].size();
    return t;
  endfunction

  function automatic logic [NCH-1:0] model_pending(input int d);
    logic [NCH-1:0] m = '0;
    for (int c = 0; c < NCH; c++) m[c] = (mq[d*NCH+c].size() > 0);
    return m;
  endfunction

  // dut 0 evicts the oldest entry on overflow, dut 1 discards the new one.
  task automatic model_push(input int d, input int ch, input logic [MW-1:0] v);
    int q = d*NCH + ch;
    if (mq[q].size() >= DEP) begin
      lost_m[q] = 1'b1;
      if (drops_m[d] < 65535) drops_m[d]++;
      if (d == 0) begin
        void'(mq[q].pop_front());
        mq[q].push_back(v);
      end
    end else begin
      mq[q].push_back(v);
    end
  endtask

  task automatic model_take(input int d, output logic [MW+7:0] rec);
    logic [MW-1:0] v;
    logic          l;
    logic [6:0]    id;
    rec = '0;
    for (int k = 1; k <= NCH; k++) begin
      int c = (rr_m[d] + k) % NCH;
      if (mq[d*NCH+c].size() > 0) begin
        v  = mq[d*NCH+c].pop_front();
        l  = lost_m[d*NCH+c];
        id = 7'(c);
        rec = {l, id, v};
        lost_m[d*NCH+c] = 1'b0;
        rr_m[d] = c;
        break;
      end
    end
  endtask

  function automatic logic [NCH*MW-1:0] rand_data();
    logic [NCH*MW-1:0] r;
    for (int i = 0; i < NCH*MW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called just after a negedge; strobes ch_valid across one posedge.
  task automatic drive_push(input int d, input logic [NCH-1:0] mask, input logic [NCH*MW-1:0] data);
    ch_valid[d] = mask;
    ch_meas[d]  = data;
    for (int c = 0; c < NCH; c++)
      if (mask[c]) model_push(d, c, data[c*MW +: MW]);
    @(negedge clk);
    ch_valid[d] = '0;
  endtask

  // Single push into an idle system; tx_start must rise 3 cycles later.
  task automatic latency(input int d, input int ch, input logic [MW-1:0] v);
    logic [NCH*MW-1:0] data;
    logic [NCH-1:0]    m;
    logic [MW+7:0]     exp_rec;
    data = '0;
    data[ch*MW +: MW] = v;
    m = '0;
    m[ch] = 1'b1;
    tx_busy[d] = 1'b0;
    drive_push(d, m, data);
    check("lat_c1", tx_start[d], 1'b0);
    @(negedge clk);
    check("lat_c2", tx_start[d], 1'b0);
    @(negedge clk);
    check("lat_c3", tx_start[d], 1'b1);
    model_take(d, exp_rec);
    check("lat_data", tx_data[d], exp_rec);
    repeat (4) @(negedge clk);
    check("lat_pending", ch_pending[d], model_pending(d));
  endtask

  // Let dut d send everything queued. mode 0: random busy 0..6 cycles,
  // mode 1: busy 10 cycles, mode 2: busy never asserted.
  task automatic drain(input int d, input int mode);
    int left, busy_left, cyc, last, tail;
    logic [MW+7:0] exp_rec;
    left = model_total(d);
    busy_left = 0;
    cyc = 0;
    last = -1;
    tail = 0;
    tx_busy[d] = 1'b0;
    while ((left > 0 || tail < 6) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (tx_start[d] === 1'b1) begin
        if (left == 0) begin
          check("extra_tx_start", tx_start[d], 1'b0);
        end else begin
          model_take(d, exp_rec);
          check("tx_data", tx_data[d], exp_rec);
          check("ch_pending", ch_pending[d], model_pending(d));
          if (last >= 0) begin
            if (d == 1) check("rate_gap_ge_100", (cyc - last >= 100), 1'b1);
            if (mode == 2) check("guard_gap", cyc - last, 4);
          end
          left--;
          busy_left = (mode == 1) ? 10 : (mode == 2) ? 0 : int'($urandom_range(0, 6));
        end
        last = cyc;
      end
      tx_busy[d] = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (left == 0 && busy_left == 0) tail++;
    end
    check("drain_left", left, 0);
    check("drop_count", drop_count[d], drops_m[d]);
  endtask

  initial begin
    logic [NCH*MW-1:0] data;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ch_valid[d] = '0;
      ch_meas[d]  = '0;
      tx_busy[d]  = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_tx_start", tx_start[d], 1'b0);
      check("rst_tx_data", tx_data[d], '0);
      check("rst_ch_pending", ch_pending[d], '0);
      check("rst_drop_count", drop_count[d], 16'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Rate-limited instance: first record right after reset is not delayed.
    latency(1, 3, 40'hA5_0000_0001);
    // Unlimited instance: ch2 record, tag 8'h02.
    latency(0, 2, 40'h12_3456_789A);

    // Simultaneous strobes on all channels, busy held 10 cycles per send.
    for (int d = 0; d < 2; d++) begin
      tx_busy[d] = 1'b1;
      drive_push(d, 4'hF, rand_data());
      drain(d, 1);
    end

    // Six pushes 1..6 on ch1 while blocked: overflow policy of each instance.
    for (int d = 0; d < 2; d++) begin
      tx_busy[d] = 1'b1;
      for (int v = 1; v <= 6; v++) begin
        data = '0;
        data[1*MW +: MW] = MW'(v);
        drive_push(d, 4'b0010, data);
      end
      check("ovf_drop_count", drop_count[d], drops_m[d]);
      drain(d, 0);
    end

    // Sender that never raises busy: FSM must free itself after tx_start.
    tx_busy[0] = 1'b1;
    for (int i = 0; i < 3; i++) drive_push(0, 4'b0001, rand_data());
    drain(0, 2);

    // Randomized bursts followed by a drain with random busy lengths.
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 2; d++) begin
        tx_busy[d] = 1'b1;
        for (int i = 0; i < int'($urandom_range(1, 7)); i++)
          drive_push(d, 4'($urandom_range(1, 15)), rand_data());
        check("burst_drop_count", drop_count[d], drops_m[d]);
        drain(d, 0);
      end
    end

    // Sustained overflow on all channels drives drop_count to saturation.
    tx_busy[0]  = 1'b1;
    ch_valid[0] = 4'hF;
    for (int i = 0; i < 16400; i++) begin
      ch_meas[0] = {NCH{MW'(i)}};
      for (int c = 0; c < NCH; c++) model_push(0, c, MW'(i));
      @(negedge clk);
    end
    ch_valid[0] = '0;
    @(negedge clk);
    check("drop_sat", drop_count[0], drops_m[0]);
    check("drop_sat_value", drop_count[0], 16'hFFFF);

    // Reset while tx_start is high: outputs clear immediately.
    tx_busy[0] = 1'b0;
    for (int i = 0; i < 20 && tx_start[0] !== 1'b1; i++) @(negedge clk);
    check("rst_pulse_seen", tx_start[0], 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_tx_start", tx_start[0], 1'b0);
    check("midrst_tx_data", tx_data[0], '0);
    check("midrst_ch_pending", ch_pending[0], '0);
    check("midrst_drop_count", drop_count[0], 16'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_pending", ch_pending[0], '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
